// File: rtl/barrett_367_pkg.sv
// rtl/barrett_367_pkg.sv - constants, types and datapath helpers for the p = 367 Barrett reducer
package barrett_367_pkg;

  localparam int unsigned P      = 367;
  localparam int unsigned K      = 18;
  localparam int unsigned MU     = (1 << K) / P;
  localparam int unsigned IN_W   = 17;
  localparam int unsigned Q_W    = 9;
  localparam int unsigned T_W    = 11;
  localparam int unsigned OUT_W  = 9;
  localparam int unsigned MU_W   = 10;
  localparam int unsigned PROD_W = IN_W + MU_W;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [Q_W-1:0]   quot_t;
  typedef logic [T_W-1:0]   rem_t;
  typedef logic [OUT_W-1:0] res_t;

  // q = floor(a * MU / 2^K); never exceeds 357 for 17-bit operands
  function automatic quot_t quot_est(input operand_t a);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(a) * PROD_W'(MU);
    return prod[K +: Q_W];
  endfunction

  // q underestimates by at most two multiples of P, so t fits in [0, 1100]
  function automatic rem_t partial_rem(input operand_t a, input quot_t q);
    operand_t qp;
    qp = IN_W'(q) * IN_W'(P);
    return T_W'(a - qp);
  endfunction

endpackage

// File: rtl/barrett_367_correct.sv
// rtl/barrett_367_correct.sv - two-threshold final correction of the Barrett partial remainder
import barrett_367_pkg::*;

module barrett_367_correct (
  input  rem_t t,
  output res_t r
);

  localparam rem_t P1 = rem_t'(P);
  localparam rem_t P2 = rem_t'(2 * P);

  rem_t t_adj;

  always_comb begin
    t_adj = t;
    if (t >= P2) begin
      t_adj = t - P2;
    end else if (t >= P1) begin
      t_adj = t - P1;
    end
    r = t_adj[OUT_W-1:0];
  end

endmodule

// File: rtl/barrett_for_367.sv
// rtl/barrett_for_367.sv - pipelined a mod 367 reducer; BARRETT_367_PIPE_EN adds a quotient register stage
import barrett_367_pkg::*;

module barrett_for_367 (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din_a,
  output logic             dout_valid,
  output logic [OUT_W-1:0] dout_r
);

  rem_t t;
  res_t res;
  logic stage_valid;

  res_t dout_r_d, dout_r_q;
  logic dout_valid_d, dout_valid_q;

`ifdef BARRETT_367_PIPE_EN
  operand_t a_d, a_q;
  quot_t    q_d, q_q;
  logic     v1_d, v1_q;

  always_comb begin
    a_d         = din_a;
    q_d         = quot_est(din_a);
    v1_d        = din_valid;
    t           = partial_rem(a_q, q_q);
    stage_valid = v1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      q_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      q_q  <= q_d;
      v1_q <= v1_d;
    end
  end
`else
  always_comb begin
    t           = partial_rem(din_a, quot_est(din_a));
    stage_valid = din_valid;
  end
`endif

  barrett_367_correct u_correct (
    .t (t),
    .r (res)
  );

  // the residue register only loads on valid so dout_r holds across bubbles
  always_comb begin
    dout_valid_d = stage_valid;
    dout_r_d     = stage_valid ? res : dout_r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      dout_r_q     <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      dout_r_q     <= dout_r_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_r     = dout_r_q;

endmodule

// File: tb/tb_barrett_for_367.sv
// tb/tb_barrett_for_367.sv - scoreboard bench for barrett_for_367 in either BARRETT_367_PIPE_EN build
module tb_barrett_for_367;

`ifdef BARRETT_367_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [8:0] r;
    int         due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        din_valid;
  logic [16:0] din_a;
  logic        dout_valid;
  logic [8:0]  dout_r;

  exp_t       sb[$];
  int         cyc;
  int         n_tests;
  int         n_fail;
  logic       mon_en;
  logic [8:0] last_r;

  barrett_for_367 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_a      (din_a),
    .dout_valid (dout_valid),
    .dout_r     (dout_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: pops the scoreboard and checks value, arrival cycle and hold behaviour
  always @(negedge clk) begin
    if (!rst_n) begin
      last_r = '0;
    end else if (mon_en) begin
      if (dout_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: dout_r=%0d at cycle %0d, no result expected", dout_r, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (dout_r !== e.r || cyc != e.due) begin
            n_fail++;
            $display("FAIL result: got %0d at cycle %0d, expected %0d at cycle %0d", dout_r, cyc, e.r, e.due);
          end
        end
        last_r = dout_r;
      end else begin
        n_tests++;
        if (dout_r !== last_r) begin
          n_fail++;
          $display("FAIL hold: dout_r=%0d while idle, expected held %0d", dout_r, last_r);
        end
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_valid: expected %0d at cycle %0d, dout_valid low", e.r, e.due);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [16:0] a, input logic [8:0] exp_r);
    exp_t e;
    @(posedge clk);
    #1;
    din_valid = v;
    din_a     = a;
    if (v) begin
      e.r   = exp_r;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    din_valid = 1'b0;
    din_a     = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dout_valid !== 1'b0 || dout_r !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_state: dout_valid=%0b dout_r=%0d, expected 0 0", dout_valid, dout_r);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_identity();
    for (int i = 0; i < 367; i++) drive(1'b1, 17'(i), 9'(i));
    drive(1'b0, '0, '0);
    drain();
  endtask

  task automatic test_corrections();
    logic [16:0] ops[6];
    logic [8:0]  res[6];
    ops = '{17'd367, 17'd733, 17'd734, 17'd1100, 17'd131019, 17'd131071};
    res = '{9'd0,    9'd366,  9'd0,    9'd366,   9'd0,       9'd52};
    for (int i = 0; i < 6; i++) drive(1'b1, ops[i], res[i]);
    drive(1'b0, '0, '0);
    drain();
  endtask

  task automatic test_random();
    logic [16:0] a;
    for (int i = 0; i < 10000; i++) begin
      a = 17'($urandom_range(131071, 0));
      drive(1'b1, a, 9'(a % 17'd367));
    end
    drive(1'b0, '0, '0);
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 17'd100,    9'd100);
    drive(1'b1, 17'd500,    9'd133);
    drive(1'b0, 17'd9999,   9'd0);
    drive(1'b1, 17'd131070, 9'd51);
    drive(1'b0, '0, '0);
    drive(1'b1, 17'd734,    9'd0);
    drive(1'b0, '0, '0);
    drive(1'b0, '0, '0);
    drive(1'b1, 17'd1000,   9'd266);
    drive(1'b0, '0, '0);
    drain();
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 17'd200, 9'd200);
    drive(1'b1, 17'd300, 9'd300);
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    rst_n     = 1'b0;
    sb.delete();
    #1;
    n_tests++;
    if (dout_valid !== 1'b0 || dout_r !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_midflight: dout_valid=%0b dout_r=%0d, expected 0 0", dout_valid, dout_r);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    drive(1'b1, 17'd368, 9'd1);
    drive(1'b0, '0, '0);
    drain();
  endtask

  initial begin
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    last_r  = '0;
    test_reset();
    test_identity();
    test_corrections();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/barrett_for_367.md
# barrett_for_367

Pipelined Barrett modular reducer for the fixed prime p = 367, part of the prime-field arithmetic library. Accepts any 17-bit unsigned operand, typically a product of two residues below 367, and returns its canonical residue in [0, 366]. Sits after field multipliers and before residue-consuming logic. Has a valid qualifier and no backpressure.

## Interface
Parameters:
- None. The modulus and Barrett constants are fixed package constants.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din_valid  input  1  din_a carries an operand this cycle.
- din_a  input  17  unsigned operand a, range 0..131071.
- dout_valid  output  1  dout_r carries a result this cycle.
- dout_r  output  9  a mod 367, range 0..366.

## Operation
- Constants: P = 367, K = 18, MU = floor(2^18 / 367) = 714.
- Quotient estimate: prod = a * MU, 27 bits unsigned. q = prod >> 18, 9 bits, q ≤ 357.
- Partial remainder: t = a − q*367. q*367 is 17 bits. t is 11 bits and lies in [0, 1100]. It is never negative.
- Correction:
  - If t ≥ 734, subtract 734.
  - Else if t ≥ 367, subtract 367.
  - Otherwise pass t unchanged.
  - Result truncated to 9 bits.
- Every 17-bit input is legal. There is no error output.
- The result is purely a function of the operand. Operands are independent, and no state carries between operations except pipeline registers.
- dout_r holds its last value while dout_valid = 0. It is not zeroed.

## Timing
- Reset, async assert: dout_valid = 0, dout_r = 0, all pipeline registers = 0. Takes effect immediately, without waiting for a clock edge.
- Reset deassert: behaves synchronously from the next rising edge.
- Operands sampled at the rising edge when din_valid = 1.
- Latency (BARRETT_367_PIPE_EN defined): 2 cycles.
  - Stage 1 registers q and a.
  - Stage 2 registers the corrected result and valid.
- Latency (macro undefined): 1 cycle. The whole datapath is combinational into the output register.
- Throughput: one operand per cycle in both configurations. Back-to-back valids produce back-to-back results in order.
- Bubbles: din_valid gaps propagate as dout_valid gaps with identical spacing.
- Reset mid-operation: all in-flight operands are discarded. No dout_valid appears for them after reset release.

## Configuration
- BARRETT_367_PIPE_EN:
  - Defined: a register is inserted between the quotient estimate and the remainder/correction logic, giving 2-cycle latency.
  - Undefined: single register stage, 1-cycle latency.
- Function and interface are identical in both builds.

## Structure
- Package barrett_367_pkg holds:
  - P, K and MU.
  - Width constants: IN_W = 17, Q_W = 9, T_W = 11, OUT_W = 9.
  - Typedefs for the operand, quotient, partial remainder and residue types.
- Sub-module barrett_367_correct: combinational, maps an 11-bit t to a 9-bit residue using the two-threshold subtraction. Instantiated once in the final stage.

## Test plan
- Exhaustive 0..366, one per cycle with din_valid = 1 -> dout_r equals the input, at the configured latency.
- Correction paths:
  - 367 -> 0.
  - 733 -> 366.
  - 734 -> 0.
  - 1100 -> 366.
  - 134000 is out of range; use 131019 -> 0.
- Upper bound: 131071 -> 52. Random sweep of 10,000 17-bit operands checked against a mod 367.
- Back-to-back and bubbles: 100, 500, idle, 131070 -> 100, 133, no output, 51, with spacing preserved.
- Reset mid-flight: assert rst_n = 0 with two operands in the pipeline -> dout_valid = 0 and dout_r = 0 immediately, with no stale output after release.
- Build-matrix check: run the same streams with BARRETT_367_PIPE_EN defined and undefined -> same results, latency 2 vs 1.
